srf_access_scheduler: RTL and testbench

Shares the streaming register file's single read port pair (src1/src2) and single write port among NUM_REQ functional-unit requesters. Per requester, read and write channels each use a valid/ready handshake. Each cycle the block picks at most one read winner and one write winner by round-robin, resolves same-cycle stream hazards, and drives the SRF enables and stream IDs from registers. Read responses are tagged with the requester ID when the SRF data becomes valid.

---
 rtl/srf_pkg.sv | 10 +
 rtl/srf_access_scheduler_rr_arbiter.sv | 32 +++
 rtl/srf_access_scheduler.sv | 152 +++++++++++++++
 tb/tb_srf_access_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/srf_pkg.sv
// Shared types and default sizing for the streaming register file access scheduler.
package srf_pkg;
  localparam int SRF_NUM_REQ          = 4;
  localparam int SRF_STREAM_ID_W      = 5;
  localparam int SRF_MAX_STALL        = 4;
  localparam int NUM_STREAM_REGISTERS = 32;

  typedef logic [SRF_STREAM_ID_W-1:0]     stream_id_t;
  typedef logic [$clog2(SRF_NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/srf_access_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);
  int               j;
  logic [IDX_W-1:0] sel;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    j         = 0;
    sel       = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      sel = IDX_W'(j);
      if (!any_o && req_i[sel]) begin
        any_o      = 1'b1;
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
      end
    end
  end
endmodule

// File: rtl/srf_access_scheduler.sv
// Arbitrates one SRF read and one SRF write per cycle among NUM_REQ requesters,
// blocking reads that collide with the same-cycle write and forcing a read slot on starvation.
module srf_access_scheduler
  import srf_pkg::*;
#(
  parameter int NUM_REQ       = SRF_NUM_REQ,
  parameter int NUM_STREAM_ID = SRF_STREAM_ID_W,
  parameter int MAX_STALL     = SRF_MAX_STALL,
  parameter int REQ_ID_W      = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     rd_req_valid,
  input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]  rd_req_src1,
  input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]  rd_req_src2,
  output logic [NUM_REQ-1:0]                     rd_req_ready,
  input  logic [NUM_REQ-1:0]                     wr_req_valid,
  input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]  wr_req_dest,
  output logic [NUM_REQ-1:0]                     wr_req_ready,
  output logic                                   srf_read_enable,
  output logic [NUM_STREAM_ID-1:0]               stream_src1,
  output logic [NUM_STREAM_ID-1:0]               stream_src2,
  output logic                                   srf_write_enable,
  output logic [NUM_STREAM_ID-1:0]               stream_dest,
  output logic [REQ_ID_W-1:0]                    wr_data_sel,
  output logic                                   rd_rsp_valid,
  output logic [REQ_ID_W-1:0]                    rd_rsp_id,
  output logic [7:0]                             hazard_stall_cnt
);
  localparam int SC_W = $clog2(MAX_STALL + 1);

  logic [NUM_REQ-1:0]       wr_req_m, wr_gnt, rd_elig, rd_gnt, hz_blk;
  logic [REQ_ID_W-1:0]      wr_idx, rd_idx;
  logic                     wr_any, rd_any, blocked;
  logic [NUM_STREAM_ID-1:0] wr_win_dest;

  logic [REQ_ID_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SC_W-1:0]          stall_q, stall_d;
  logic                     force_read_q, force_read_d;
  logic [7:0]               hz_cnt_q, hz_cnt_d;

  logic                     rd_en_q, wr_en_q, rsp_v1_q, rsp_v2_q;
  logic [NUM_STREAM_ID-1:0] src1_q, src2_q, dest_q;
  logic [REQ_ID_W-1:0]      sel_q, rsp_id1_q, rsp_id2_q;

  function automatic logic [REQ_ID_W-1:0] next_idx(input logic [REQ_ID_W-1:0] i);
    return (i == REQ_ID_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // A forced read cycle takes the write side out of contention entirely.
  assign wr_req_m = force_read_q ? '0 : wr_req_valid;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(REQ_ID_W)) u_wr_arb (
    .req_i    (wr_req_m),
    .ptr_i    (wr_ptr_q),
    .gnt_o    (wr_gnt),
    .gnt_idx_o(wr_idx),
    .any_o    (wr_any)
  );

  assign wr_win_dest = wr_req_dest[wr_idx];

  always_comb begin
    hz_blk = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hz_blk[i] = rd_req_valid[i] && wr_any &&
                  ((rd_req_src1[i] == wr_win_dest) || (rd_req_src2[i] == wr_win_dest));
    end
  end

  assign rd_elig = rd_req_valid & ~hz_blk;
  assign blocked = |hz_blk;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(REQ_ID_W)) u_rd_arb (
    .req_i    (rd_elig),
    .ptr_i    (rd_ptr_q),
    .gnt_o    (rd_gnt),
    .gnt_idx_o(rd_idx),
    .any_o    (rd_any)
  );

  assign rd_req_ready = rst ? rd_gnt : '0;
  assign wr_req_ready = rst ? wr_gnt : '0;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    stall_d      = stall_q;
    force_read_d = 1'b0;
    hz_cnt_d     = hz_cnt_q;
    if (wr_any) wr_ptr_d = next_idx(wr_idx);
    if (rd_any) rd_ptr_d = next_idx(rd_idx);
    if (rd_any) begin
      stall_d = '0;
    end else if (blocked) begin
      if (stall_q == SC_W'(MAX_STALL - 1)) begin
        stall_d      = '0;
        force_read_d = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
    if (blocked && (hz_cnt_q != 8'hFF)) hz_cnt_d = hz_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stall_q      <= '0;
      force_read_q <= 1'b0;
      hz_cnt_q     <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      dest_q       <= '0;
      sel_q        <= '0;
      rsp_v1_q     <= 1'b0;
      rsp_id1_q    <= '0;
      rsp_v2_q     <= 1'b0;
      rsp_id2_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stall_q      <= stall_d;
      force_read_q <= force_read_d;
      hz_cnt_q     <= hz_cnt_d;
      rd_en_q      <= rd_any;
      wr_en_q      <= wr_any;
      src1_q       <= rd_any ? rd_req_src1[rd_idx] : '0;
      src2_q       <= rd_any ? rd_req_src2[rd_idx] : '0;
      dest_q       <= wr_any ? wr_win_dest : '0;
      sel_q        <= wr_any ? wr_idx : '0;
      // Response tag rides two stages so it lines up with SRF read data.
      rsp_v1_q     <= rd_any;
      rsp_id1_q    <= rd_any ? rd_idx : '0;
      rsp_v2_q     <= rsp_v1_q;
      rsp_id2_q    <= rsp_id1_q;
    end
  end

  assign srf_read_enable  = rd_en_q;
  assign stream_src1      = src1_q;
  assign stream_src2      = src2_q;
  assign srf_write_enable = wr_en_q;
  assign stream_dest      = dest_q;
  assign wr_data_sel      = sel_q;
  assign rd_rsp_valid     = rsp_v2_q;
  assign rd_rsp_id        = rsp_id2_q;
  assign hazard_stall_cnt = hz_cnt_q;
endmodule

// File: tb/tb_srf_access_scheduler.sv
// Directed bench for srf_access_scheduler: per-cycle vector table plus reset and starvation sequences.
module tb_srf_access_scheduler;
  logic                 clk;
  logic                 rst;
  logic [3:0]           rd_req_valid;
  logic [3:0][4:0]      rd_req_src1, rd_req_src2;
  logic [3:0]           rd_req_ready;
  logic [3:0]           wr_req_valid;
  logic [3:0][4:0]      wr_req_dest;
  logic [3:0]           wr_req_ready;
  logic                 srf_read_enable, srf_write_enable, rd_rsp_valid;
  logic [4:0]           stream_src1, stream_src2, stream_dest;
  logic [1:0]           wr_data_sel, rd_rsp_id;
  logic [7:0]           hazard_stall_cnt;

  int checks = 0;
  int errors = 0;

  srf_access_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .rd_req_valid    (rd_req_valid),
    .rd_req_src1     (rd_req_src1),
    .rd_req_src2     (rd_req_src2),
    .rd_req_ready    (rd_req_ready),
    .wr_req_valid    (wr_req_valid),
    .wr_req_dest     (wr_req_dest),
    .wr_req_ready    (wr_req_ready),
    .srf_read_enable (srf_read_enable),
    .stream_src1     (stream_src1),
    .stream_src2     (stream_src2),
    .srf_write_enable(srf_write_enable),
    .stream_dest     (stream_dest),
    .wr_data_sel     (wr_data_sel),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_id       (rd_rsp_id),
    .hazard_stall_cnt(hazard_stall_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      rv;
    logic [3:0][4:0] s1, s2;
    logic [3:0]      wv;
    logic [3:0][4:0] wd;
    logic [3:0]      e_rrdy, e_wrdy;
    logic            e_sre;
    logic [4:0]      e_s1, e_s2;
    logic            e_swe;
    logic [4:0]      e_dest;
    logic [1:0]      e_sel;
    logic            e_rsp;
    logic [1:0]      e_id;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [19:0] p4(input logic [4:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [3:0] rv, input logic [19:0] s1, s2,
                              input logic [3:0] wv, input logic [19:0] wd,
                              input logic [3:0] err, ewr,
                              input logic esre, input logic [4:0] es1, es2,
                              input logic eswe, input logic [4:0] ed, input logic [1:0] esel,
                              input logic ersp, input logic [1:0] eid);
    vec_t v;
    v.rv = rv; v.s1 = s1; v.s2 = s2; v.wv = wv; v.wd = wd;
    v.e_rrdy = err; v.e_wrdy = ewr;
    v.e_sre = esre; v.e_s1 = es1; v.e_s2 = es2;
    v.e_swe = eswe; v.e_dest = ed; v.e_sel = esel;
    v.e_rsp = ersp; v.e_id = eid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    rd_req_valid = v.rv;
    rd_req_src1  = v.s1;
    rd_req_src2  = v.s2;
    wr_req_valid = v.wv;
    wr_req_dest  = v.wd;
  endtask

  task automatic idle();
    rd_req_valid = '0;
    rd_req_src1  = '0;
    rd_req_src2  = '0;
    wr_req_valid = '0;
    wr_req_dest  = '0;
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    #2;
    chk("rd_req_ready", 32'(rd_req_ready), 32'(v.e_rrdy));
    chk("wr_req_ready", 32'(wr_req_ready), 32'(v.e_wrdy));
    @(posedge clk);
    #1;
    chk("srf_read_enable", 32'(srf_read_enable), 32'(v.e_sre));
    if (v.e_sre) begin
      chk("stream_src1", 32'(stream_src1), 32'(v.e_s1));
      chk("stream_src2", 32'(stream_src2), 32'(v.e_s2));
    end
    chk("srf_write_enable", 32'(srf_write_enable), 32'(v.e_swe));
    if (v.e_swe) begin
      chk("stream_dest", 32'(stream_dest), 32'(v.e_dest));
      chk("wr_data_sel", 32'(wr_data_sel), 32'(v.e_sel));
    end
    chk("rd_rsp_valid", 32'(rd_rsp_valid), 32'(v.e_rsp));
    if (v.e_rsp) chk("rd_rsp_id", 32'(rd_rsp_id), 32'(v.e_id));
  endtask

  logic [19:0] z;
  logic [7:0]  exp_hz[6];

  initial begin
    z = '0;
    //            rv       s1                s2                wv       wd                   rrdy     wrdy     sre  s1  s2  swe  dst sel  rsp id
    tbl[0]  = mk(4'b0100, z,                p4(0,4,0,0),      4'b0000, z,                  4'b0100, 4'b0000, 1,   0,  4,  0,   0,  0,   0,  0);
    tbl[1]  = mk(4'b0000, z,                z,                4'b0000, z,                  4'b0000, 4'b0000, 0,   0,  0,  0,   0,  0,   1,  2);
    tbl[2]  = mk(4'b0000, z,                z,                4'b1111, p4(11,10,9,8),      4'b0000, 4'b0001, 0,   0,  0,  1,   8,  0,   0,  0);
    tbl[3]  = mk(4'b0000, z,                z,                4'b1111, p4(11,10,9,8),      4'b0000, 4'b0010, 0,   0,  0,  1,   9,  1,   0,  0);
    tbl[4]  = mk(4'b0000, z,                z,                4'b1111, p4(11,10,9,8),      4'b0000, 4'b0100, 0,   0,  0,  1,  10,  2,   0,  0);
    tbl[5]  = mk(4'b0000, z,                z,                4'b1111, p4(11,10,9,8),      4'b0000, 4'b1000, 0,   0,  0,  1,  11,  3,   0,  0);
    tbl[6]  = mk(4'b0000, z,                z,                4'b1111, p4(11,10,9,8),      4'b0000, 4'b0001, 0,   0,  0,  1,   8,  0,   0,  0);
    tbl[7]  = mk(4'b0001, p4(0,0,0,1),      p4(0,0,0,4),      4'b0010, p4(0,0,4,0),        4'b0000, 4'b0010, 0,   0,  0,  1,   4,  1,   0,  0);
    tbl[8]  = mk(4'b0001, p4(0,0,0,1),      p4(0,0,0,4),      4'b0000, z,                  4'b0001, 4'b0000, 1,   1,  4,  0,   0,  0,   0,  0);
    tbl[9]  = mk(4'b0000, z,                z,                4'b0000, z,                  4'b0000, 4'b0000, 0,   0,  0,  0,   0,  0,   1,  0);
    tbl[10] = mk(4'b0010, z,                p4(0,0,4,0),      4'b1000, p4(7,0,0,0),        4'b0010, 4'b1000, 1,   0,  4,  1,   7,  3,   0,  0);
    tbl[11] = mk(4'b0000, z,                z,                4'b0000, z,                  4'b0000, 4'b0000, 0,   0,  0,  0,   0,  0,   1,  1);
    tbl[12] = mk(4'b1000, p4(5,0,0,0),      p4(5,0,0,0),      4'b0000, z,                  4'b1000, 4'b0000, 1,   5,  5,  0,   0,  0,   0,  0);
    tbl[13] = mk(4'b0000, z,                z,                4'b0000, z,                  4'b0000, 4'b0000, 0,   0,  0,  0,   0,  0,   1,  3);
    tbl[14] = mk(4'b1011, p4(2,0,2,2),      p4(3,0,3,3),      4'b0000, z,                  4'b0001, 4'b0000, 1,   2,  3,  0,   0,  0,   0,  0);
    tbl[15] = mk(4'b1010, p4(2,0,2,2),      p4(3,0,3,3),      4'b0000, z,                  4'b0010, 4'b0000, 1,   2,  3,  0,   0,  0,   1,  0);
    tbl[16] = mk(4'b1000, p4(2,0,2,2),      p4(3,0,3,3),      4'b0000, z,                  4'b1000, 4'b0000, 1,   2,  3,  0,   0,  0,   1,  1);
    tbl[17] = mk(4'b0000, z,                z,                4'b0000, z,                  4'b0000, 4'b0000, 0,   0,  0,  0,   0,  0,   1,  3);

    // reset state, with every requester valid so gated readies are exercised
    rst = 1'b0;
    idle();
    rd_req_valid = 4'b1111;
    wr_req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_req_ready", 32'(rd_req_ready), 32'h0);
    chk("reset wr_req_ready", 32'(wr_req_ready), 32'h0);
    chk("reset srf_read_enable", 32'(srf_read_enable), 32'h0);
    chk("reset srf_write_enable", 32'(srf_write_enable), 32'h0);
    chk("reset rd_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("reset hazard_stall_cnt", 32'(hazard_stall_cnt), 32'h0);
    idle();
    rst = 1'b1;

    for (int n = 0; n < 18; n++) apply(tbl[n]);

    // reset asserted while a read is being issued
    idle();
    rd_req_valid   = 4'b0001;
    rd_req_src2[0] = 5'd4;
    #2;
    chk("mid rd_req_ready", 32'(rd_req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("mid srf_read_enable pre", 32'(srf_read_enable), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("mid srf_read_enable", 32'(srf_read_enable), 32'h0);
    chk("mid stream_src2", 32'(stream_src2), 32'h0);
    chk("mid rd_req_ready", 32'(rd_req_ready), 32'h0);
    chk("mid rd_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("mid hazard_stall_cnt", 32'(hazard_stall_cnt), 32'h0);
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post-reset rd_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    end

    // starvation guard: writer 0 to stream 4 every cycle, reader 2 of stream 4
    exp_hz = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
    for (int s = 0; s < 6; s++) begin
      idle();
      wr_req_valid   = 4'b0001;
      wr_req_dest[0] = 5'd4;
      if (s <= 4) begin
        rd_req_valid   = 4'b0100;
        rd_req_src1[2] = 5'd4;
        rd_req_src2[2] = 5'd9;
      end
      #2;
      chk("starve wr_req_ready", 32'(wr_req_ready), (s == 4) ? 32'h0 : 32'h1);
      chk("starve rd_req_ready", 32'(rd_req_ready), (s == 4) ? 32'h4 : 32'h0);
      @(posedge clk);
      #1;
      chk("starve hazard_stall_cnt", 32'(hazard_stall_cnt), 32'(exp_hz[s]));
      chk("starve srf_read_enable", 32'(srf_read_enable), (s == 4) ? 32'h1 : 32'h0);
      chk("starve srf_write_enable", 32'(srf_write_enable), (s == 4) ? 32'h0 : 32'h1);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
